// File: rtl/ts_sync_pkg.sv
// ts_sync_pkg: shared widths, lock-state encodings and helpers for the sync-time receiver
package ts_sync_pkg;
   localparam int TIME_W = 48;
   typedef enum logic [1:0] {
      ST_UNSYNC  = 2'b00,
      ST_LOCKING = 2'b01,
      ST_LOCKED  = 2'b10
   } state_t;
   function automatic logic [TIME_W-1:0] abs_time(input logic [TIME_W-1:0] v);
      return v[TIME_W-1] ? -v : v;
   endfunction
endpackage

// File: rtl/ts_sync_watchdog.sv
// ts_sync_watchdog: counts cycles since the last strobe and pulses once when the timeout is reached
module ts_sync_watchdog
   import ts_sync_pkg::*;
#(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_expire
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt;
   // cleared by a strobe, otherwise counts up and parks at the timeout value
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) cnt <= '0;
      else if (i_clear) cnt <= '0;
      else if (cnt != CW'(TIMEOUT_CYC)) cnt <= cnt + CW'(1);
   end
   assign o_expire = !i_clear && cnt == CW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/ts_sync_time_receiver.sv
// ts_sync_time_receiver: disciplined 48-bit local time with offset reporting and lock tracking
module ts_sync_time_receiver
   import ts_sync_pkg::*;
#(
   parameter int STEP_NS     = 8,
   parameter int MAX_OFF_NS  = 64,
   parameter int LOCK_CNT    = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_sync_time_wr,
   input  logic [TIME_W-1:0] iv_sync_time,
   output logic [TIME_W-1:0] ov_local_time,
   output logic              o_time_valid,
   output logic [1:0]        ov_state,
   output logic [TIME_W-1:0] ov_offset,
   output logic              o_offset_wr,
   output logic              o_sync_lost,
   output logic [15:0]       ov_update_cnt
);
   localparam int GW = $clog2(LOCK_CNT + 1);
   state_t            state, state_n;
   logic [GW-1:0]     good_cnt, good_cnt_n;
   logic [TIME_W-1:0] off;
   logic              good, expire, lost_n;
   assign off          = iv_sync_time - ov_local_time;
   assign good         = abs_time(off) <= TIME_W'(MAX_OFF_NS);
   assign ov_state     = state;
   assign o_time_valid = state == ST_LOCKED;
   ts_sync_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_sync_time_wr),
      .o_expire(expire)
   );
   // local time free-runs, a strobe reloads it and publishes the measured offset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ov_local_time <= '0;
         ov_offset     <= '0;
         o_offset_wr   <= 1'b0;
         o_sync_lost   <= 1'b0;
         ov_update_cnt <= '0;
      end else begin
         ov_local_time <= (i_sync_time_wr ? iv_sync_time : ov_local_time) + TIME_W'(STEP_NS);
         o_offset_wr   <= i_sync_time_wr;
         o_sync_lost   <= lost_n;
         ov_update_cnt <= ov_update_cnt + 16'(i_sync_time_wr);
         if (i_sync_time_wr) ov_offset <= off;
      end
   end
   // lock state and consecutive-good counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ST_UNSYNC;
         good_cnt <= '0;
      end else begin
         state    <= state_n;
         good_cnt <= good_cnt_n;
      end
   end
   // strobes judge the offset; a watchdog expiry without a strobe drops back to UNSYNC
   always_comb begin
      state_n    = state;
      good_cnt_n = good_cnt;
      lost_n     = 1'b0;
      if (i_sync_time_wr) begin
         case (state)
            ST_UNSYNC: begin
               state_n    = ST_LOCKING;
               good_cnt_n = '0;
            end
            ST_LOCKING: begin
               good_cnt_n = good ? good_cnt + GW'(1) : '0;
               if (good && 32'(good_cnt) + 1 == LOCK_CNT) begin
                  state_n    = ST_LOCKED;
                  good_cnt_n = '0;
               end
            end
            ST_LOCKED: if (!good) begin
               state_n    = ST_LOCKING;
               good_cnt_n = '0;
               lost_n     = 1'b1;
            end
            default: begin
               state_n    = ST_UNSYNC;
               good_cnt_n = '0;
            end
         endcase
      end else if (expire && state != ST_UNSYNC) begin
         state_n    = ST_UNSYNC;
         good_cnt_n = '0;
         lost_n     = 1'b1;
      end
   end
endmodule

// File: tb/tb_ts_sync_time_receiver.sv
// tb_ts_sync_time_receiver: randomized scoreboard bench for the sync-time receiver
module tb_ts_sync_time_receiver;
   localparam int STEP = 8;
   localparam int MAXOFF = 64;
   localparam int LOCKN = 4;
   localparam int TMO = 4096;
   typedef struct {
      logic [47:0] off;
      logic [15:0] cnt;
      logic        lost;
   } rec_t;
   logic        clk = 1'b0;
   logic        rst;
   logic        i_sync_time_wr;
   logic [47:0] iv_sync_time;
   logic [47:0] ov_local_time;
   logic        o_time_valid;
   logic [1:0]  ov_state;
   logic [47:0] ov_offset;
   logic        o_offset_wr;
   logic        o_sync_lost;
   logic [15:0] ov_update_cnt;
   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;
   rec_t sq[$];
   int   lq[$];
   rec_t mr;
   logic [47:0] m_local;
   logic [1:0]  m_st;
   int          m_goods;
   int          m_idle;
   logic [15:0] m_upd;
   logic [47:0] exp_local;
   logic [1:0]  exp_state;

   ts_sync_time_receiver #(
      .STEP_NS(STEP), .MAX_OFF_NS(MAXOFF), .LOCK_CNT(LOCKN), .TIMEOUT_CYC(TMO)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_sync_time_wr(i_sync_time_wr),
      .iv_sync_time  (iv_sync_time),
      .ov_local_time (ov_local_time),
      .o_time_valid  (o_time_valid),
      .ov_state      (ov_state),
      .ov_offset     (ov_offset),
      .o_offset_wr   (o_offset_wr),
      .o_sync_lost   (o_sync_lost),
      .ov_update_cnt (ov_update_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_local = '0; m_st = 2'd0; m_goods = 0; m_idle = 0; m_upd = '0;
      exp_local = '0; exp_state = 2'd0;
      sq.delete(); lq.delete();
   endtask

   // reference behaviour: what the outputs must show after the coming clock edge
   task automatic model_step(input logic s, input logic [47:0] v);
      logic [47:0] off;
      longint so;
      logic good, lost;
      if (s) begin
         off  = v - m_local;
         so   = off[47] ? longint'(off) - (longint'(1) <<< 48) : longint'(off);
         good = so >= -MAXOFF && so <= MAXOFF;
         lost = 1'b0;
         if (m_st == 2'd0) begin
            m_st = 2'd1; m_goods = 0;
         end else if (m_st == 2'd1) begin
            m_goods = good ? m_goods + 1 : 0;
            if (m_goods == LOCKN) begin m_st = 2'd2; m_goods = 0; end
         end else if (!good) begin
            m_st = 2'd1; m_goods = 0; lost = 1'b1;
         end
         m_upd = m_upd + 16'd1;
         sq.push_back('{off: off, cnt: m_upd, lost: lost});
         m_local = v + 48'(STEP);
         m_idle = 0;
      end else begin
         m_local = m_local + 48'(STEP);
         if (m_idle < TMO) begin
            m_idle++;
            if (m_idle == TMO && m_st != 2'd0) begin
               m_st = 2'd0; m_goods = 0; lq.push_back(1);
            end
         end
      end
      exp_local = m_local;
      exp_state = m_st;
   endtask

   task automatic cyc(input logic s, input logic [47:0] v);
      i_sync_time_wr = s;
      iv_sync_time   = v;
      model_step(s, v);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, '0);
   endtask

   task automatic track(input int n, input int gap);
      for (int k = 0; k < n; k++) begin
         idle(gap);
         cyc(1'b1, m_local);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_local"}, ov_local_time, 0);
      chk({tag, "_state"}, 48'(ov_state), 0);
      chk({tag, "_valid"}, 48'(o_time_valid), 0);
      chk({tag, "_offset"}, ov_offset, 0);
      chk({tag, "_offset_wr"}, 48'(o_offset_wr), 0);
      chk({tag, "_lost"}, 48'(o_sync_lost), 0);
      chk({tag, "_updcnt"}, 48'(ov_update_cnt), 0);
   endtask

   // monitor: per-cycle time/state compare, pops the scoreboard whenever the DUT reports
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("local_time", ov_local_time, exp_local);
         chk("state", 48'(ov_state), 48'(exp_state));
         chk("time_valid", 48'(o_time_valid), 48'(exp_state == 2'd2));
         if (o_offset_wr) begin
            if (sq.size() == 0) chk("offset_wr_unexpected", 48'(o_offset_wr), 0);
            else begin
               mr = sq.pop_front();
               chk("offset", ov_offset, mr.off);
               chk("update_cnt", 48'(ov_update_cnt), 48'(mr.cnt));
               chk("lost_on_strobe", 48'(o_sync_lost), 48'(mr.lost));
            end
         end else begin
            if (sq.size() != 0) begin
               mr = sq.pop_front();
               chk("offset_wr_missing", 48'(o_offset_wr), 1);
            end
            if (o_sync_lost) begin
               if (lq.size() == 0) chk("sync_lost_unexpected", 48'(o_sync_lost), 0);
               else begin
                  void'(lq.pop_front());
                  chk("sync_lost_timeout", 48'(o_sync_lost), 1);
               end
            end else if (lq.size() != 0) begin
               void'(lq.pop_front());
               chk("sync_lost_missing", 48'(o_sync_lost), 1);
            end
         end
      end
   end

   initial begin
      int r;
      logic [47:0] v;
      i_sync_time_wr = 1'b0;
      iv_sync_time = '0;
      rst = 1'b0;
      model_reset();
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      chk_en = 1'b1;
      // free-running after reset
      idle(100);
      chk("t1_local_800", ov_local_time, 48'd800);
      // first strobe in UNSYNC
      cyc(1'b1, 48'd1000);
      chk("t2_offset", ov_offset, 48'd200);
      chk("t2_local", ov_local_time, 48'd1008);
      chk("t2_offset_wr", 48'(o_offset_wr), 1);
      chk("t2_state", 48'(ov_state), 1);
      // exact tracking locks after four good updates
      track(4, 1250);
      chk("t3_state", 48'(ov_state), 2);
      chk("t3_valid", 48'(o_time_valid), 1);
      chk("t3_updcnt", 48'(ov_update_cnt), 5);
      chk("t3_offset", ov_offset, 0);
      // large offset while locked, then boundary -64 counts as good
      idle(20);
      cyc(1'b1, m_local + 48'd200);
      chk("t4_offset", ov_offset, 48'd200);
      chk("t4_state", 48'(ov_state), 1);
      chk("t4_lost", 48'(o_sync_lost), 1);
      idle(10);
      cyc(1'b1, m_local - 48'd64);
      chk("t4_offset_neg", ov_offset, -48'd64);
      track(2, 10);
      chk("t4_still_locking", 48'(ov_state), 1);
      track(1, 10);
      chk("t4_relocked", 48'(ov_state), 2);
      // timeout drops lock; strobe on the timeout cycle keeps it
      idle(TMO - 1);
      chk("t5_before_tmo", 48'(ov_state), 2);
      idle(1);
      chk("t5_tmo_state", 48'(ov_state), 0);
      chk("t5_tmo_lost", 48'(o_sync_lost), 1);
      idle(5);
      track(5, 10);
      chk("t5_relock", 48'(ov_state), 2);
      idle(TMO - 1);
      cyc(1'b1, m_local);
      chk("t5_race_state", 48'(ov_state), 2);
      chk("t5_race_lost", 48'(o_sync_lost), 0);
      // 48-bit wrap in offset and in free-running time, back-to-back strobes
      cyc(1'b1, 48'hFFFF_FFFF_FFF0);
      cyc(1'b1, 48'd0);
      chk("t6_wrap_offset", ov_offset, 48'd8);
      chk("t6_wrap_local", ov_local_time, 48'd8);
      cyc(1'b1, 48'hFFFF_FFFF_FFE8);
      idle(5);
      track(4, 3);
      // randomized strobes, offsets around the limits and one long silence
      for (int i = 0; i < 250; i++) begin
         idle($urandom_range(0, 30));
         r = $urandom_range(0, 9);
         if (r <= 5) v = m_local + 48'($signed($urandom_range(0, 140)) - 70);
         else if (r == 6) v = m_local + 48'h8000_0000_0000;
         else if (r == 7) v = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
         else if (r == 8) v = ($urandom_range(0, 1) != 0) ? m_local + 48'd64 : m_local - 48'd64;
         else v = ($urandom_range(0, 1) != 0) ? m_local + 48'd65 : m_local - 48'd65;
         cyc(1'b1, v);
         if (i == 120) idle(TMO + 100);
      end
      // asynchronous reset while locked
      track(5, 7);
      chk("t6_locked_before_rst", 48'(ov_state), 2);
      cyc(1'b0, '0);
      chk_en = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check_zero("midrst");
      repeat (2) @(negedge clk);
      model_reset();
      rst = 1'b0;
      chk_en = 1'b1;
      idle(3);
      track(5, 4);
      chk("t7_relock_after_rst", 48'(ov_state), 2);
      chk("t7_updcnt", 48'(ov_update_cnt), 5);
      idle(3);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
